// File: rtl/ref_mem_array.sv
// Banked reference-pixel memory: BANKS independent 1R+1W banks and a 2-stage read path
// (bank read, then lane rotation into a registered output). Optional write-through
// forwarding on same-address collisions is built only when REF_MEM_BYPASS_EN is defined.
module ref_mem_array #(
  parameter int PIX_W = 8,
  parameter int BANKS = 32,
  parameter int AW    = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BANKS-1:0]       Bank_sel,
  input  logic [AW*BANKS-1:0]    write_address_all,
  input  logic [PIX_W*BANKS-1:0] wr_data_all,
  input  logic [AW*BANKS-1:0]    rd_address_all,
  input  logic                   rd8R_en,
  input  logic [3:0]             rdR_sel,
  output logic [PIX_W*BANKS-1:0] rd_data_all,
  output logic                   rd_valid,
  output logic                   dbg_rd_state
);

  localparam int DEPTH = 1 << AW;
  localparam int BW    = $clog2(BANKS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } rd_state_e;

  rd_state_e state, state_nxt;

  // Read handshake: a request is accepted on every rising edge where rd8R_en is low
  // (there is no ready/backpressure). Its data appears registered one edge later,
  // with rd_valid high for exactly that one cycle.
  logic             rd_req_q;
  logic [3:0]       sel_q;
  logic [PIX_W-1:0] bank_rd [BANKS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_req_q <= 1'b0;
      sel_q    <= '0;
    end else begin
      rd_req_q <= !rd8R_en;
      if (!rd8R_en) sel_q <= rdR_sel;
    end
  end

  for (genvar k = 0; k < BANKS; k++) begin : g_bank
    logic [AW-1:0]    wa;
    logic [AW-1:0]    ra;
    logic [PIX_W-1:0] wd;
    logic             we;
    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] q;

    assign wa = write_address_all[AW*k +: AW];
    assign ra = rd_address_all[AW*k +: AW];
    assign wd = wr_data_all[PIX_W*k +: PIX_W];
    assign we = Bank_sel[k];

    // Contents are never cleared; only writes presented during reset are suppressed.
    always_ff @(posedge clk) begin
      if (rst_n && we) mem[wa] <= wd;
    end

`ifdef REF_MEM_BYPASS_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (!rd8R_en) begin
        q <= (we && (wa == ra)) ? wd : mem[ra];
      end
    end
`else
    // Non-blocking write above makes a same-address read return the old word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (!rd8R_en) begin
        q <= mem[ra];
      end
    end
`endif

    assign bank_rd[k] = q;
  end

  // Output lane i carries bank (i + 2*sel) mod BANKS.
  logic [PIX_W*BANKS-1:0] rot;
  logic [BW-1:0]          idx;

  always_comb begin
    rot = '0;
    idx = '0;
    for (int i = 0; i < BANKS; i++) begin
      idx = BW'((i + 2 * int'(sel_q)) % BANKS);
      rot[i*PIX_W +: PIX_W] = bank_rd[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rd_data_all <= '0;
    end else begin
      state <= state_nxt;
      if (rd_req_q) rd_data_all <= rot;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (rd_req_q)  state_nxt = ST_VALID;
      ST_VALID: if (!rd_req_q) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign rd_valid     = (state == ST_VALID);
  assign dbg_rd_state = (state == ST_VALID);

endmodule

// File: tb/tb_ref_mem_array.sv
// Directed bench for ref_mem_array: write/read, rotation, streaming reads,
// collisions, top-bank enable isolation and reset during an in-flight read.
module tb_ref_mem_array;
  localparam int PIX_W = 8;
  localparam int BANKS = 32;
  localparam int AW    = 7;

  logic                   clk;
  logic                   rst_n;
  logic [BANKS-1:0]       Bank_sel;
  logic [AW*BANKS-1:0]    write_address_all;
  logic [PIX_W*BANKS-1:0] wr_data_all;
  logic [AW*BANKS-1:0]    rd_address_all;
  logic                   rd8R_en;
  logic [3:0]             rdR_sel;
  logic [PIX_W*BANKS-1:0] rd_data_all;
  logic                   rd_valid;
  logic                   dbg_rd_state;

  int errors = 0;
  int checks = 0;

`ifdef REF_MEM_BYPASS_EN
  localparam logic [PIX_W-1:0] COLL_EXP = 8'hAA;
`else
  localparam logic [PIX_W-1:0] COLL_EXP = 8'h55;
`endif

  ref_mem_array #(.PIX_W(PIX_W), .BANKS(BANKS), .AW(AW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Bank_sel          (Bank_sel),
    .write_address_all (write_address_all),
    .wr_data_all       (wr_data_all),
    .rd_address_all    (rd_address_all),
    .rd8R_en           (rd8R_en),
    .rdR_sel           (rdR_sel),
    .rd_data_all       (rd_data_all),
    .rd_valid          (rd_valid),
    .dbg_rd_state      (dbg_rd_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd_addr(input logic [AW-1:0] a);
    for (int k = 0; k < BANKS; k++) rd_address_all[k*AW +: AW] = a;
  endtask

  task automatic set_wr_addr(input logic [AW-1:0] a);
    for (int k = 0; k < BANKS; k++) write_address_all[k*AW +: AW] = a;
  endtask

  task automatic idle_inputs();
    Bank_sel = '0;
    rd8R_en  = 1'b1;
    rdR_sel  = '0;
  endtask

  // One accepted read; on return the result is on the outputs.
  task automatic read_issue(input logic [AW-1:0] a, input logic [3:0] sel);
    set_rd_addr(a);
    rdR_sel = sel;
    rd8R_en = 1'b0;
    tick();
    rd8R_en = 1'b1;
    tick();
  endtask

  function automatic logic [PIX_W-1:0] lane(input int i);
    return rd_data_all[i*PIX_W +: PIX_W];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", rd_valid); end
    checks++;
    if (rd_data_all !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", rd_data_all); end
    checks++;
    if (dbg_rd_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %0b expected 0", dbg_rd_state); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %0b expected 0", rd_valid); end
  endtask

  task automatic test_write_read();
    logic [PIX_W-1:0] e;
    Bank_sel = 32'h0000_000F;
    set_wr_addr(7'd5);
    for (int k = 0; k < 4; k++) wr_data_all[k*PIX_W +: PIX_W] = 8'(17 * (k + 1));
    tick();
    Bank_sel = '0;
    read_issue(7'd5, 4'd0);
    checks++;
    if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", rd_valid); end
    for (int i = 0; i < 4; i++) begin
      e = 8'(17 * (i + 1));
      checks++;
      if (lane(i) !== e) begin errors++; $display("FAIL basic_lane%0d: got %0h expected %0h", i, lane(i), e); end
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %0b expected 0", rd_valid); end
    checks++;
    if (lane(3) !== 8'h44) begin errors++; $display("FAIL basic_hold: got %0h expected 44", lane(3)); end
  endtask

  task automatic test_rotation();
    Bank_sel = '1;
    set_wr_addr(7'd0);
    for (int k = 0; k < BANKS; k++) wr_data_all[k*PIX_W +: PIX_W] = 8'(k);
    tick();
    Bank_sel = '0;
    read_issue(7'd0, 4'd3);
    checks++;
    if (lane(0) !== 8'd6) begin errors++; $display("FAIL rot3_lane0: got %0d expected 6", lane(0)); end
    checks++;
    if (lane(25) !== 8'd31) begin errors++; $display("FAIL rot3_lane25: got %0d expected 31", lane(25)); end
    checks++;
    if (lane(26) !== 8'd0) begin errors++; $display("FAIL rot3_lane26: got %0d expected 0", lane(26)); end
    checks++;
    if (lane(31) !== 8'd5) begin errors++; $display("FAIL rot3_lane31: got %0d expected 5", lane(31)); end
    read_issue(7'd0, 4'd15);
    checks++;
    if (lane(0) !== 8'd30) begin errors++; $display("FAIL rot15_lane0: got %0d expected 30", lane(0)); end
    checks++;
    if (lane(2) !== 8'd0) begin errors++; $display("FAIL rot15_lane2: got %0d expected 0", lane(2)); end
    read_issue(7'd0, 4'd0);
    for (int i = 0; i < BANKS; i++) begin
      checks++;
      if (lane(i) !== 8'(i)) begin errors++; $display("FAIL rot0_lane%0d: got %0d expected %0d", i, lane(i), i); end
    end
  endtask

  task automatic test_back_to_back();
    logic [PIX_W-1:0] e;
    for (int a = 0; a < 4; a++) begin
      Bank_sel = '1;
      set_wr_addr(7'(a));
      for (int k = 0; k < BANKS; k++) wr_data_all[k*PIX_W +: PIX_W] = 8'(8'hA0 + a);
      tick();
    end
    Bank_sel = '0;
    rdR_sel  = '0;
    rd8R_en  = 1'b0;
    set_rd_addr(7'd0);
    tick();
    for (int a = 1; a <= 4; a++) begin
      if (a < 4) set_rd_addr(7'(a));
      else rd8R_en = 1'b1;
      tick();
      e = 8'(8'hA0 + a - 1);
      checks++;
      if (rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %0b expected 1", a, rd_valid); end
      checks++;
      if (lane(0) !== e) begin errors++; $display("FAIL b2b_lane0_%0d: got %0h expected %0h", a, lane(0), e); end
      checks++;
      if (lane(31) !== e) begin errors++; $display("FAIL b2b_lane31_%0d: got %0h expected %0h", a, lane(31), e); end
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %0b expected 0", rd_valid); end
    checks++;
    if (lane(0) !== 8'hA3) begin errors++; $display("FAIL b2b_hold: got %0h expected a3", lane(0)); end
  endtask

  task automatic test_collision();
    Bank_sel = 32'h0000_0080;
    set_wr_addr(7'd9);
    wr_data_all[7*PIX_W +: PIX_W] = 8'h55;
    tick();
    wr_data_all[7*PIX_W +: PIX_W] = 8'hAA;
    set_rd_addr(7'd9);
    rdR_sel = '0;
    rd8R_en = 1'b0;
    tick();
    Bank_sel = '0;
    rd8R_en  = 1'b1;
    tick();
    checks++;
    if (lane(7) !== COLL_EXP) begin errors++; $display("FAIL coll_same: got %0h expected %0h", lane(7), COLL_EXP); end
    read_issue(7'd9, 4'd0);
    checks++;
    if (lane(7) !== 8'hAA) begin errors++; $display("FAIL coll_after: got %0h expected aa", lane(7)); end
    // Different address in the same bank: both ports complete.
    Bank_sel = 32'h0000_0080;
    set_wr_addr(7'd10);
    wr_data_all[7*PIX_W +: PIX_W] = 8'h3C;
    set_rd_addr(7'd9);
    rd8R_en = 1'b0;
    tick();
    Bank_sel = '0;
    rd8R_en  = 1'b1;
    tick();
    checks++;
    if (lane(7) !== 8'hAA) begin errors++; $display("FAIL dual_port_rd: got %0h expected aa", lane(7)); end
    read_issue(7'd10, 4'd0);
    checks++;
    if (lane(7) !== 8'h3C) begin errors++; $display("FAIL dual_port_wr: got %0h expected 3c", lane(7)); end
  endtask

  task automatic test_top_bank();
    logic [PIX_W-1:0] e;
    Bank_sel = '1;
    set_wr_addr(7'd127);
    for (int k = 0; k < BANKS; k++) wr_data_all[k*PIX_W +: PIX_W] = 8'(8'h40 + k);
    tick();
    Bank_sel = 32'h8000_0000;
    for (int k = 0; k < BANKS; k++) wr_data_all[k*PIX_W +: PIX_W] = 8'hFF;
    tick();
    Bank_sel = '0;
    read_issue(7'd127, 4'd0);
    for (int k = 0; k < BANKS; k++) begin
      e = (k == 31) ? 8'hFF : 8'(8'h40 + k);
      checks++;
      if (lane(k) !== e) begin errors++; $display("FAIL top_bank_lane%0d: got %0h expected %0h", k, lane(k), e); end
    end
  endtask

  task automatic test_reset_mid_read();
    Bank_sel = 32'h0000_0004;
    set_wr_addr(7'd50);
    wr_data_all[2*PIX_W +: PIX_W] = 8'h12;
    tick();
    Bank_sel = '0;
    set_rd_addr(7'd50);
    rd8R_en = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    // Activity during reset must be ignored.
    Bank_sel = 32'h0000_0004;
    wr_data_all[2*PIX_W +: PIX_W] = 8'h77;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid%0d: got %0b expected 0", c, rd_valid); end
      checks++;
      if (rd_data_all !== '0) begin errors++; $display("FAIL rst_mid_data%0d: got %0h expected 0", c, rd_data_all); end
    end
    rst_n = 1'b1;
    idle_inputs();
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid: got %0b expected 0", rd_valid); end
    checks++;
    if (rd_data_all !== '0) begin errors++; $display("FAIL rst_release_data: got %0h expected 0", rd_data_all); end
    read_issue(7'd50, 4'd0);
    checks++;
    if (lane(2) !== 8'h12) begin errors++; $display("FAIL rst_retained: got %0h expected 12", lane(2)); end
    checks++;
    if (lane(1) !== 8'd1) begin errors++; $display("FAIL rst_retained_b1: got %0h expected 1", lane(1)); end
  endtask

  initial begin
    rst_n             = 1'b0;
    Bank_sel          = '0;
    write_address_all = '0;
    wr_data_all       = '0;
    rd_address_all    = '0;
    rd8R_en           = 1'b1;
    rdR_sel           = '0;
    test_reset();
    test_write_read();
    test_rotation();
    test_back_to_back();
    test_collision();
    test_top_bank();
    // Bank 1 addr 50 is seeded so a second lane can be checked after reset.
    Bank_sel = 32'h0000_0002;
    set_wr_addr(7'd50);
    wr_data_all[1*PIX_W +: PIX_W] = 8'd1;
    tick();
    Bank_sel = '0;
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
